// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer: takes a stream of 24-bit pixels and turns it into framebuffer
// writes for one frame of H_RES x V_RES pixels, in raster order.
// Optional feature: define FB_DOUBLE_BUFFER_EN to add a back-buffer select bit
// (fb_sel, MSB of fb_addr) that flips after every completed frame, plus disp_sel.
//
// Handshakes: a pixel transfers on a rising edge where s_axis_a_tvalid and
// s_axis_a_tready are both high; a framebuffer write transfers on a rising edge
// where fb_we and fb_wr_ready are both high. fb_we/fb_addr/fb_data hold steady
// until their transfer completes, and tvalid/tdata are never looked at unless
// tready is high.
module pixel_fb_writer #(
   parameter int H_RES  = 320,
   parameter int V_RES  = 180,
   parameter int ADDR_W = 16
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              start,
   input  logic [23:0]       s_axis_a_tdata,
   input  logic              s_axis_a_tvalid,
   output logic              s_axis_a_tready,
   output logic              fb_we,
`ifdef FB_DOUBLE_BUFFER_EN
   output logic [ADDR_W:0]   fb_addr,
   output logic              fb_sel,
   output logic              disp_sel,
`else
   output logic [ADDR_W-1:0] fb_addr,
`endif
   output logic [23:0]       fb_data,
   input  logic              fb_wr_ready,
   output logic              busy,
   output logic              frame_done,
   output logic [1:0]        state_dbg
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WRITE = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;

   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

   logic [1:0]        state;
   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] addr_q;
   logic              sel_q;

   logic enter_write;
   logic pix_accept;
   logic wr_accept;
   logic last_pix;

   // Handshake decode. A start in the frame_done cycle is dropped so a frame
   // cannot be re-armed by the very pulse that reports the previous one.
   always_comb begin
      enter_write     = (state == IDLE) && start && !frame_done;
      wr_accept       = fb_we && fb_wr_ready;
      s_axis_a_tready = (state == WRITE) && (!fb_we || fb_wr_ready);
      pix_accept      = s_axis_a_tready && s_axis_a_tvalid;
      last_pix        = (x == X_LAST) && (y == Y_LAST);
   end

   // Frame sequencing: IDLE -> WRITE on start, WRITE -> FLUSH on the last
   // pixel, FLUSH -> IDLE once that last pixel's write has been taken.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (enter_write)            state <= WRITE;
            WRITE:   if (pix_accept && last_pix) state <= FLUSH;
            FLUSH:   if (wr_accept)              state <= IDLE;
            default:                             state <= IDLE;
         endcase
      end
   end

   // Raster position and running linear index; the index stands in for
   // y*H_RES + x so no multiplier is needed.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         x   <= '0;
         y   <= '0;
         idx <= '0;
      end else if (enter_write) begin
         x   <= '0;
         y   <= '0;
         idx <= '0;
      end else if (pix_accept) begin
         idx <= idx + ADDR_W'(1);
         if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + YW'(1);
         end else begin
            x <= x + XW'(1);
         end
      end
   end

   // Write request register: loaded on every accepted pixel, which may be the
   // same cycle the previous write drains, so the pipe can run at one per clock.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         fb_we   <= 1'b0;
         addr_q  <= '0;
         fb_data <= '0;
      end else if (pix_accept) begin
         fb_we   <= 1'b1;
         addr_q  <= idx;
         fb_data <= s_axis_a_tdata;
      end else if (wr_accept) begin
         fb_we   <= 1'b0;
      end
   end

   // End-of-frame pulse and buffer select flip, both on the final write.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         frame_done <= 1'b0;
         sel_q      <= 1'b0;
      end else begin
         frame_done <= (state == FLUSH) && wr_accept;
         if ((state == FLUSH) && wr_accept) sel_q <= !sel_q;
      end
   end

`ifdef FB_DOUBLE_BUFFER_EN
   assign fb_addr  = {sel_q, addr_q};
   assign fb_sel   = sel_q;
   assign disp_sel = !sel_q;
`else
   assign fb_addr  = addr_q;
   // Single-buffer build: every frame lands in the same region.
   logic unused_sel;
   assign unused_sel = sel_q;
`endif

   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: doc/pixel_fb_writer.md
PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 Parameter H_RES, default 320, pixels per line (>=2).
REQ-002 Parameter V_RES, default 180, lines per frame (>=2).
REQ-003 Parameter ADDR_W, default 16, framebuffer address width; H_RES*V_RES <= 2**ADDR_W.
REQ-004 Port aclk  in  1  sole clock, all logic on rising edge.
REQ-005 Port areset  in  1  reset, asynchronous, active-high.
REQ-006 Port start  in  1  single-cycle request to begin a frame.
REQ-007 Port s_axis_a_tdata  in  24  pixel {B[23:16], G[15:8], R[7:0]} from the vec-to-pixel-color stage.
REQ-008 Port s_axis_a_tvalid  in  1  pixel valid.
REQ-009 Port s_axis_a_tready  out  1  pixel accepted when tvalid && tready.
REQ-010 Port fb_we  out  1  framebuffer write request, held until fb_wr_ready.
REQ-011 Port fb_addr  out  ADDR_W  write address.
REQ-012 Port fb_data  out  24  write data.
REQ-013 Port fb_wr_ready  in  1  framebuffer accepts the write when fb_we && fb_wr_ready.
REQ-014 Port busy  out  1  high while a frame is in progress.
REQ-015 Port frame_done  out  1  single-cycle pulse after the last write of a frame is accepted.

Function
REQ-016 FSM states: IDLE, WRITE, FLUSH.
- IDLE -> WRITE on start.
- WRITE -> FLUSH when pixel H_RES*V_RES-1 is accepted.
- FLUSH -> IDLE when the pending write is accepted, with frame_done pulsed that cycle.
REQ-017 start is ignored outside IDLE.
REQ-018 s_axis_a_tready = (state==WRITE) && (!fb_we || fb_wr_ready); it is 0 in IDLE and FLUSH.
REQ-019 Accepted pixel is registered: fb_we=1, fb_data=tdata, fb_addr=current pixel index, on the next cycle (latency 1).
REQ-020 A pixel may be accepted in the same cycle a pending write is accepted, giving full throughput of 1 pixel/cycle.
REQ-021 fb_we, fb_addr and fb_data stay stable while fb_we && !fb_wr_ready.
REQ-022 Counters x (0..H_RES-1) and y (0..V_RES-1) advance on each acceptance; x wraps to 0 and y increments at x==H_RES-1.
REQ-023 fb_addr = y*H_RES + x, computed incrementally as a running index, with no multiplier.
REQ-024 x, y and the index clear to 0 on entry to WRITE.
REQ-025 fb_we drops to 0 the cycle after acceptance unless a new pixel was accepted in the same cycle.
REQ-026 busy = (state != IDLE).
REQ-027 A start arriving in the same cycle frame_done pulses is ignored.

Reset
REQ-028 While areset is high, regardless of clock:
- state = IDLE; x, y and index = 0.
- fb_we = 0, fb_addr = 0, fb_data = 0.
- busy = 0, frame_done = 0, s_axis_a_tready = 0.
REQ-029 Reset mid-frame discards the pending write and any partial frame; no frame_done is produced.

Configuration
REQ-030 Macro FB_DOUBLE_BUFFER_EN defined:
- Adds output port fb_sel (1 bit, reset 0), which is ANDed into nothing and is prepended as the MSB of fb_addr, making fb_addr ADDR_W+1 bits wide.
- fb_sel selects the back buffer being written.
- fb_sel toggles in the cycle frame_done pulses.
- Adds output port disp_sel = !fb_sel for the display reader.
REQ-031 Macro FB_DOUBLE_BUFFER_EN undefined: no fb_sel/disp_sel ports, fb_addr is ADDR_W bits, and all frames write the same region.

Verification (H_RES=4, V_RES=2 unless stated)
REQ-032 Reset, then start, tvalid=1 and fb_wr_ready=1 constantly:
- 8 writes on consecutive cycles, addr 0..7, data matching input.
- frame_done pulses one cycle after the addr-7 write is accepted.
- tready=0 after the 8th accept.
REQ-033 fb_wr_ready held 0 for 3 cycles during write addr 2:
- fb_we, addr and data stable for those cycles.
- tready=0 during the stall.
- No pixel is lost or duplicated.
REQ-034 Pixel accepted at x=3, y=0 -> fb_addr=3; the next accepted pixel -> fb_addr=4 (x=0, y=1).
REQ-035 start pulsed mid-frame and in IDLE with tvalid=1 but no start:
- The mid-frame start does not reset the counters.
- In IDLE, tready stays 0 and no writes are issued.
REQ-036 areset asserted asynchronously after the 5th accept:
- Outputs go to reset values immediately.
- No frame_done is produced.
- A following start rewrites from addr 0.
REQ-037 With FB_DOUBLE_BUFFER_EN, two back-to-back frames:
- Frame 1 addresses carry fb_sel=0 (MSB 0); frame 2 addresses carry fb_sel=1.
- disp_sel toggles coincident with each frame_done.
